// File: rtl/microwave_ctrl_v2.sv
// Microwave controller: keypad shift-in time entry, BCD countdown driven by an
// internal 1 s tick divider, power-level duty cycling of the magnetron,
// pause/resume, quick-start and an end-of-cook beep, all under one FSM.
module microwave_ctrl_v2 #(
  parameter int TICK_DIV     = 100,
  parameter int MIN_DIGITS   = 1,
  parameter int POWER_WINDOW = 10,
  parameter int BEEP_TICKS   = 3,
  parameter int QUICK_SECS   = 30
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    startn,
  input  logic                    stopn,
  input  logic                    clearn,
  input  logic                    door_closed,
  input  logic [9:0]              keypad,
  input  logic [3:0]              power_level,
  output logic [3:0]              sec_ones,
  output logic [3:0]              sec_tens,
  output logic [4*MIN_DIGITS-1:0] mins,
  output logic                    mag_on,
  output logic                    beep,
  output logic [2:0]              state
);

  localparam int MW = 4 * MIN_DIGITS;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int WW = (POWER_WINDOW > 1) ? $clog2(POWER_WINDOW) : 1;
  localparam int BW = $clog2(BEEP_TICKS + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SET   = 3'd1,
    S_COOK  = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          r_state, w_state_nxt;

  logic            r_startn_q, r_stopn_q, r_clearn_q;
  logic [9:0]      r_keypad_q;

  logic [3:0]      r_sec_ones, r_sec_tens;
  logic [MW-1:0]   r_mins;
  logic [3:0]      r_power;
  logic [TW-1:0]   r_tick_cnt;
  logic [WW-1:0]   r_window_cnt;
  logic [BW-1:0]   r_beep_cnt;

  logic            w_start_ev, w_stop_ev, w_clear_ev, w_key_ev;
  logic [3:0]      w_key_val;
  logic [MW-1:0]   w_shift_mins;
  logic            w_shift_zero;
  logic [3:0]      w_dec_ones, w_dec_tens;
  logic [MW-1:0]   w_dec_mins;
  logic            w_dec_zero;
  logic            w_tick_run, w_tick;
  logic [3:0]      w_power_eff;

  // Datapath commands issued by the next-state logic.
  logic            w_do_clear_time, w_do_quick, w_do_shift, w_do_dec;
  logic            w_cook_fresh, w_cook_resume, w_latch_power;
  logic            w_beep_clr, w_beep_inc;

  // Borrowing BCD decrement across all minute digits, LSD first.
  function automatic logic [MW-1:0] bcd_dec(input logic [MW-1:0] v);
    logic [MW-1:0] r;
    logic          borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < MIN_DIGITS; i++) begin
      if (borrow) begin
        if (r[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Previous samples of buttons and keypad for edge detection.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_startn_q <= 1'b1;
      r_stopn_q  <= 1'b1;
      r_clearn_q <= 1'b1;
      r_keypad_q <= '0;
    end else begin
      r_startn_q <= startn;
      r_stopn_q  <= stopn;
      r_clearn_q <= clearn;
      r_keypad_q <= keypad;
    end
  end

  assign w_start_ev = r_startn_q & ~startn;
  assign w_stop_ev  = r_stopn_q  & ~stopn;
  assign w_clear_ev = r_clearn_q & ~clearn;
  assign w_key_ev   = (|keypad) & ~(|r_keypad_q);

  // Lowest set key index wins: scan downwards so the last hit is the lowest.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (which would infer a latch).
    w_key_val = 4'd0;
    for (int i = 9; i >= 0; i--) begin
      if (keypad[i]) w_key_val = 4'(i);
    end
  end

  // Shift-in and decrement candidates for the time digits.
  always_comb begin
    w_shift_mins = (r_mins << 4) | MW'(r_sec_tens);
    w_shift_zero = (w_key_val == 4'd0) && (r_sec_ones == 4'd0) && (w_shift_mins == '0);

    w_dec_ones = r_sec_ones;
    w_dec_tens = r_sec_tens;
    w_dec_mins = r_mins;
    if (r_sec_ones != 4'd0) begin
      w_dec_ones = r_sec_ones - 4'd1;
    end else begin
      w_dec_ones = 4'd9;
      if (r_sec_tens != 4'd0) begin
        w_dec_tens = r_sec_tens - 4'd1;
      end else begin
        w_dec_tens = 4'd5;
        w_dec_mins = bcd_dec(r_mins);
      end
    end
    w_dec_zero = (w_dec_ones == 4'd0) && (w_dec_tens == 4'd0) && (w_dec_mins == '0);
  end

  assign w_tick_run  = (r_state == S_COOK) || (r_state == S_DONE);
  assign w_tick      = w_tick_run && (r_tick_cnt == TW'(TICK_DIV - 1));
  assign w_power_eff = ((power_level == 4'd0) || (power_level > 4'd10)) ? 4'd10 : power_level;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state uses non-blocking (<=) so all flops update together from pre-edge values.
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic; event priority is clear > stop > start > key.
  always_comb begin
    w_state_nxt     = r_state;
    w_do_clear_time = 1'b0;
    w_do_quick      = 1'b0;
    w_do_shift      = 1'b0;
    w_do_dec        = 1'b0;
    w_cook_fresh    = 1'b0;
    w_cook_resume   = 1'b0;
    w_latch_power   = 1'b0;
    w_beep_clr      = 1'b0;
    w_beep_inc      = 1'b0;
    case (r_state)
      S_IDLE, S_SET: begin
        if (w_clear_ev) begin
          w_state_nxt     = S_IDLE;
          w_do_clear_time = 1'b1;
        end else if (w_stop_ev) begin
          // Stop does nothing here, but it still outranks start and keys.
        end else if (w_start_ev) begin
          if (door_closed) begin
            w_do_quick    = (r_state == S_IDLE);
            w_latch_power = 1'b1;
            w_cook_fresh  = 1'b1;
            w_state_nxt   = S_COOK;
          end
        end else if (w_key_ev) begin
          w_do_shift  = 1'b1;
          w_state_nxt = w_shift_zero ? S_IDLE : S_SET;
        end
      end
      S_COOK: begin
        if (w_clear_ev) begin
          w_state_nxt     = S_IDLE;
          w_do_clear_time = 1'b1;
        end else if (w_stop_ev || !door_closed) begin
          w_state_nxt = S_PAUSE;
        end else if (w_tick) begin
          w_do_dec = 1'b1;
          if (w_dec_zero) begin
            w_state_nxt = S_DONE;
            w_beep_clr  = 1'b1;
          end
        end
      end
      S_PAUSE: begin
        if (w_clear_ev || w_stop_ev) begin
          w_state_nxt     = S_IDLE;
          w_do_clear_time = 1'b1;
        end else if (w_start_ev && door_closed) begin
          w_cook_resume = 1'b1;
          w_state_nxt   = S_COOK;
        end
      end
      S_DONE: begin
        if (w_clear_ev || w_stop_ev || w_start_ev || !door_closed) begin
          w_state_nxt     = S_IDLE;
          w_do_clear_time = 1'b1;
        end else if (w_tick) begin
          if (r_beep_cnt == BW'(BEEP_TICKS - 1)) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_beep_inc = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_do_clear_time = 1'b1;
      end
    endcase
  end

  // Time digits, latched power and the tick / window / beep counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sec_ones   <= 4'd0;
      r_sec_tens   <= 4'd0;
      r_mins       <= '0;
      r_power      <= 4'd0;
      r_tick_cnt   <= '0;
      r_window_cnt <= '0;
      r_beep_cnt   <= '0;
    end else begin
      if (w_do_clear_time) begin
        r_sec_ones <= 4'd0;
        r_sec_tens <= 4'd0;
        r_mins     <= '0;
      end else if (w_do_quick) begin
        r_sec_ones <= 4'(QUICK_SECS % 10);
        r_sec_tens <= 4'(QUICK_SECS / 10);
        r_mins     <= '0;
      end else if (w_do_shift) begin
        r_sec_ones <= w_key_val;
        r_sec_tens <= r_sec_ones;
        r_mins     <= w_shift_mins;
      end else if (w_do_dec) begin
        r_sec_ones <= w_dec_ones;
        r_sec_tens <= w_dec_tens;
        r_mins     <= w_dec_mins;
      end

      if (w_latch_power) r_power <= w_power_eff;

      if (w_cook_fresh || w_cook_resume) begin
        r_tick_cnt <= '0;
      end else if (w_tick_run) begin
        r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
      end

      // Window position survives a pause so the duty pattern continues.
      if (w_cook_fresh) begin
        r_window_cnt <= '0;
      end else if (w_do_dec) begin
        r_window_cnt <= (r_window_cnt == WW'(POWER_WINDOW - 1)) ? '0 : r_window_cnt + WW'(1);
      end

      if (w_beep_clr)      r_beep_cnt <= '0;
      else if (w_beep_inc) r_beep_cnt <= r_beep_cnt + BW'(1);
    end
  end

  // Outputs; mag_on follows door_closed combinationally so it drops at once.
  always_comb begin
    mag_on = 1'b0;
    beep   = 1'b0;
    if (r_state == S_COOK) begin
      mag_on = door_closed && (8'(r_window_cnt) < 8'(r_power));
    end
    if (r_state == S_DONE) begin
      beep = 1'b1;
    end
  end

  assign sec_ones = r_sec_ones;
  assign sec_tens = r_sec_tens;
  assign mins     = r_mins;
  assign state    = r_state;

endmodule

// File: tb/tb_microwave_ctrl_v2.sv
// Directed bench for microwave_ctrl_v2 with a 4-cycle tick; inputs change and
// outputs are sampled on the falling clock edge.
module tb_microwave_ctrl_v2;

  logic       clk = 1'b0;
  logic       resetn;
  logic       startn, stopn, clearn;
  logic       door_closed;
  logic [9:0] keypad;
  logic [3:0] power_level;
  logic [3:0] sec_ones, sec_tens;
  logic [3:0] mins;
  logic       mag_on, beep;
  logic [2:0] state;

  int n_checks = 0;
  int n_errors = 0;

  microwave_ctrl_v2 #(
    .TICK_DIV    (4),
    .MIN_DIGITS  (1),
    .POWER_WINDOW(10),
    .BEEP_TICKS  (3),
    .QUICK_SECS  (30)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .startn     (startn),
    .stopn      (stopn),
    .clearn     (clearn),
    .door_closed(door_closed),
    .keypad     (keypad),
    .power_level(power_level),
    .sec_ones   (sec_ones),
    .sec_tens   (sec_tens),
    .mins       (mins),
    .mag_on     (mag_on),
    .beep       (beep),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_time(input string tag, input int m, input int t, input int o);
    check({tag, "_mins"}, int'(mins), m);
    check({tag, "_tens"}, int'(sec_tens), t);
    check({tag, "_ones"}, int'(sec_ones), o);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold the key for one edge, then release for one edge.
  task automatic press_key(input int k);
    keypad = 10'b1 << k;
    @(negedge clk);
    keypad = '0;
    @(negedge clk);
  endtask

  // 0 = start, 1 = stop, 2 = clear; returns just after the edge that sees it.
  task automatic press(input int which);
    if (which == 0) startn = 1'b0;
    if (which == 1) stopn  = 1'b0;
    if (which == 2) clearn = 1'b0;
    @(negedge clk);
    startn = 1'b1;
    stopn  = 1'b1;
    clearn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn      = 1'b0;
    startn      = 1'b1;
    stopn       = 1'b1;
    clearn      = 1'b1;
    door_closed = 1'b1;
    keypad      = '0;
    power_level = 4'd10;
    cycles(3);
    check("rst_state", int'(state), 0);
    check_time("rst", 0, 0, 0);
    check("rst_mag", int'(mag_on), 0);
    check("rst_beep", int'(beep), 0);
    resetn = 1'b1;
    cycles(1);

    // 1: shift-in entry, leading digit drops out.
    press_key(1);
    press_key(2);
    press_key(5);
    check_time("t1_125", 1, 2, 5);
    check("t1_state", int'(state), 1);
    check("t1_mag", int'(mag_on), 0);
    press_key(4);
    check_time("t1_254", 2, 5, 4);

    // 2: clear, zero key keeps IDLE, cook 0:03 to DONE and beep out.
    press(2);
    check("t2_clr_state", int'(state), 0);
    check_time("t2_clr", 0, 0, 0);
    press_key(0);
    check("t2_key0_state", int'(state), 0);
    press_key(3);
    check("t2_set_state", int'(state), 1);
    press(0);
    check("t2_cook_state", int'(state), 2);
    check("t2_cook_mag", int'(mag_on), 1);
    cycles(11);
    check_time("t2_e11", 0, 0, 1);
    check("t2_e11_state", int'(state), 2);
    cycles(1);
    check_time("t2_e12", 0, 0, 0);
    check("t2_done_state", int'(state), 4);
    check("t2_done_mag", int'(mag_on), 0);
    check("t2_done_beep", int'(beep), 1);
    cycles(11);
    check("t2_beep_end_state", int'(state), 4);
    check("t2_beep_end_beep", int'(beep), 1);
    cycles(1);
    check("t2_idle_state", int'(state), 0);
    check("t2_idle_beep", int'(beep), 0);

    // 3: minute borrow, then a tens digit of 9 counting down.
    press_key(1);
    press_key(0);
    press_key(0);
    check_time("t3_100", 1, 0, 0);
    press(0);
    cycles(4);
    check_time("t3_059", 0, 5, 9);
    press(2);
    check("t3_clr_state", int'(state), 0);
    press_key(9);
    press_key(0);
    check_time("t3_090", 0, 9, 0);
    press(0);
    for (int i = 1; i <= 10; i++) begin
      cycles(4);
      check_time($sformatf("t3_tick%0d", i), 0, 8, 10 - i);
    end
    cycles(4);
    check_time("t3_079", 0, 7, 9);
    press(2);

    // 4: door opens mid-tick, pause freezes, resume, stop twice.
    press_key(1);
    press_key(0);
    press(0);
    cycles(2);
    door_closed = 1'b0;
    #1;
    check("t4_door_mag", int'(mag_on), 0);
    check("t4_door_state", int'(state), 2);
    @(negedge clk);
    check("t4_pause_state", int'(state), 3);
    check_time("t4_pause", 0, 1, 0);
    cycles(8);
    check("t4_frozen_state", int'(state), 3);
    check_time("t4_frozen", 0, 1, 0);
    door_closed = 1'b1;
    cycles(1);
    press(0);
    check("t4_resume_state", int'(state), 2);
    cycles(4);
    check_time("t4_009", 0, 0, 9);
    cycles(1);
    press(1);
    check("t4_stop_state", int'(state), 3);
    check_time("t4_stop", 0, 0, 9);
    cycles(1);
    press(1);
    check("t4_stop2_state", int'(state), 0);
    check_time("t4_stop2", 0, 0, 0);

    // 5: power 3 gives three on-ticks per ten in both windows.
    power_level = 4'd3;
    press_key(2);
    press_key(0);
    press(0);
    cycles(1);
    for (int k = 0; k < 20; k++) begin
      check($sformatf("t5_mag_k%0d", k), int'(mag_on), ((k % 10) < 3) ? 1 : 0);
      cycles(4);
    end
    check("t5_done_state", int'(state), 4);
    check("t5_done_beep", int'(beep), 1);
    press(2);
    check("t5_abort_state", int'(state), 0);
    check("t5_abort_beep", int'(beep), 0);
    power_level = 4'd10;

    // 6: clear beats start, quick start, door-open start blocked.
    press_key(7);
    check("t6_set_state", int'(state), 1);
    clearn = 1'b0;
    startn = 1'b0;
    @(negedge clk);
    clearn = 1'b1;
    startn = 1'b1;
    check("t6_prio_state", int'(state), 0);
    check_time("t6_prio", 0, 0, 0);
    cycles(1);
    press(0);
    check("t6_quick_state", int'(state), 2);
    check_time("t6_quick", 0, 3, 0);
    press(2);
    press_key(5);
    door_closed = 1'b0;
    press(0);
    check("t6_blocked_state", int'(state), 1);
    check_time("t6_blocked", 0, 0, 5);
    door_closed = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
